// File: rtl/bster_pkg.sv
// Shared types and default widths for the RAM initiator.
package bster_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 8;

  // INIT clears the RAM; RUN serves write and read requests.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ram_initiator_rsp_fifo.sv
// Two-entry response FIFO holding read data until the consumer accepts it.
module rsp_fifo
  import bster_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  // Pointers and occupancy; one-bit pointers wrap modulo 2 by construction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign valid = (count != 2'd0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/ram_initiator.sv
// RAM initiator: clears the RAM after reset, then arbitrates write and read
// requests onto the RAM ports and returns read data in request order.
module ram_initiator
  import bster_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_addr_in,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr_out,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] SWEEP_LAST = '1;

  state_t            state;
  logic [ADDR_W-1:0] sweep;
  logic              run;
  logic              wr_fire;
  logic              rd_fire_p0;
  logic              vld_p1;
  logic              pop;
  logic [1:0]        fifo_count;
  logic [1:0]        occ;

  // FSM: sweep every address once with zeros, then stay in RUN until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep     <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          sweep <= sweep + ADDR_W'(1);
          if (sweep == SWEEP_LAST) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign run = (state == ST_RUN);

  // Write path: the sweep owns the write port in INIT, requests own it in RUN.
  assign wr_ready    = run;
  assign wr_fire     = wr_valid & run;
  assign ram_wr_en   = run ? wr_fire : 1'b1;
  assign ram_addr_in = run ? wr_addr : sweep;
  assign ram_data_in = run ? wr_data : '0;

  // Read admission: in-flight plus buffered responses may never exceed two.
  // A response leaving this cycle frees its slot at once, which is what lets
  // a steady stream run at one read per cycle.
  assign pop          = rsp_valid & rsp_ready;
  assign occ          = fifo_count + {1'b0, vld_p1};
  assign rd_ready     = run & ((occ < 2'd2) | pop);
  assign rd_fire_p0   = rd_valid & rd_ready;
  assign ram_rd_en    = rd_fire_p0;
  assign ram_addr_out = rd_addr;

  // ---- stage p0 -> p1: RAM read in progress, data registered by the RAM ----
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= rd_fire_p0;
  end

  // ---- stage p1 -> p2: RAM data captured into the response FIFO ----
  rsp_fifo #(
    .DATA_W (DATA_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_p1),
    .push_data (ram_data_out),
    .pop       (pop),
    .valid     (rsp_valid),
    .head      (rsp_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ram_initiator.sv
// Randomized bench for ram_initiator with a behavioural RAM and a
// transaction-level reference model (shadow memory + ordered response queue).
module tb_ram_initiator;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int NADDR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          ram_wr_en, ram_rd_en;
  logic [AW-1:0] ram_addr_in, ram_addr_out;
  logic [DW-1:0] ram_data_in, ram_data_out;
  logic          init_done;

  always #5 clk = ~clk;

  ram_initiator #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_addr      (rd_addr),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .ram_wr_en    (ram_wr_en),
    .ram_addr_in  (ram_addr_in),
    .ram_data_in  (ram_data_in),
    .ram_rd_en    (ram_rd_en),
    .ram_addr_out (ram_addr_out),
    .ram_data_out (ram_data_out),
    .init_done    (init_done)
  );

  // Behavioural RAM: registered read, old data on a same-address collision.
  logic [DW-1:0] ram [NADDR];
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_addr_in] <= ram_data_in;
    if (ram_rd_en) ram_data_out <= ram[ram_addr_out];
  end

  // Reference model state.
  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } rsp_t;

  logic [DW-1:0] shadow [NADDR];
  rsp_t          exp_q[$];
  int            cyc;
  int            since_rst;
  int            n_vec;
  int            n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rv, input logic [AW-1:0] ra, input logic rr);
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
    rd_valid  = rv;
    rd_addr   = ra;
    rsp_ready = rr;
  endtask

  // Compare every output against the model for the current cycle, then
  // advance the model by what the upcoming clock edge will commit.
  task automatic observe();
    logic done_exp, vld_exp, pop, rdy_exp, rfire, wfire;
    done_exp = (since_rst >= NADDR);
    chk("init_done", init_done, done_exp);
    chk("wr_ready", wr_ready, done_exp);
    if (!done_exp) begin
      chk("sweep_wr_en", ram_wr_en, 1'b1);
      chk("sweep_addr", ram_addr_in, since_rst);
      chk("sweep_data", ram_data_in, 0);
      chk("init_rd_en", ram_rd_en, 1'b0);
    end
    vld_exp = (exp_q.size() > 0) && (cyc - exp_q[0].t >= 2);
    chk("rsp_valid", rsp_valid, vld_exp);
    if (vld_exp) chk("rsp_data", rsp_data, exp_q[0].d);
    pop     = vld_exp && rsp_ready;
    rdy_exp = done_exp && ((exp_q.size() - (pop ? 1 : 0)) < 2);
    chk("rd_ready", rd_ready, rdy_exp);
    wfire = done_exp && wr_valid;
    rfire = rdy_exp && rd_valid;
    if (done_exp) begin
      chk("wr_en", ram_wr_en, wfire);
      if (wfire) begin
        chk("wr_addr", ram_addr_in, wr_addr);
        chk("wr_data", ram_data_in, wr_data);
      end
      chk("rd_en", ram_rd_en, rfire);
      if (rfire) chk("rd_addr", ram_addr_out, rd_addr);
    end
    if (pop) void'(exp_q.pop_front());
    if (rfire) exp_q.push_back('{d: shadow[rd_addr], t: cyc});
    if (wfire) shadow[wr_addr] = wr_data;
    cyc++;
    since_rst++;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NADDR; i++) shadow[i] = '0;
    since_rst = 0;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rd_ready", rd_ready, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_rd_en", ram_rd_en, 1'b0);
    observe();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    since_rst = 0;
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Clear sweep, then read every address back as zero.
    repeat (6) tick();
    for (int a = 0; a < NADDR; a++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(a), 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (4) tick();

    // Write then read the next cycle.
    drive(1'b1, 2'd2, 8'hA5, 1'b0, '0, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b1, 2'd2, 1'b1);    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (3) tick();

    // Same-cycle write/read collision returns the old value.
    drive(1'b1, 2'd1, 8'h11, 1'b0, '0, 1'b1); tick();
    drive(1'b1, 2'd1, 8'h3C, 1'b1, 2'd1, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b1, 2'd1, 1'b1);    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (3) tick();

    // Backpressure: only two reads admitted, data held, then drained in order.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(k), 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    repeat (2) tick();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (3) tick();

    // Back-to-back reads at full rate.
    for (int a = 0; a < NADDR; a++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(a), 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (3) tick();

    // Reset with two responses buffered; earlier data must read back as zero.
    drive(1'b1, 2'd3, 8'h77, 1'b0, '0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b1, 2'd3, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b1, 2'd2, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    repeat (2) tick();
    do_reset();
    repeat (5) tick();
    for (int a = 0; a < NADDR; a++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(a), 1'b1);
      tick();
    end

    // Randomized traffic, with an occasional reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom),
              $urandom_range(0, 2) != 0, AW'($urandom), $urandom_range(0, 3) != 0);
        tick();
      end
    end

    // Drain whatever is left, bounded.
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) tick();
    chk("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
